// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
//
// Receiver for one toggle-coverage group. Per-point hit strobes are folded
// into a sticky bitmap; each point hit for the first time is reported once, as
// its absolute cover index, over a valid/ready stream. A saturating count of
// covered points is kept alongside.
//
// Ports:
//   clock_i          rising-edge clock
//   reset_i          asynchronous active-high reset, clears all state
//   valid_i          per-point hit strobes, sampled every edge
//   clear_i          synchronous clear of all coverage state
//   out_valid_o      out_index_o holds an unreported newly covered point
//   out_ready_i      consumer accepts out_index_o
//   out_index_o      absolute cover index (COVER_INDEX + point)
//   covered_map_o    sticky hit bitmap
//   covered_count_o  saturating count of covered points
//   all_covered_o    every point of the group has been hit
module cover_toggle_collector #(
  parameter int unsigned     WIDTH       = 2,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 8940,
  parameter int unsigned     IDX_W       = 64,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [WIDTH-1:0]  valid_i,
  input  logic              clear_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  out_index_o,
  output logic [WIDTH-1:0]  covered_map_o,
  output logic [CNT_W-1:0]  covered_count_o,
  output logic              all_covered_o
);

  localparam int unsigned SelW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Elaboration-time sanity: an illegal parameter set lands in this block.
  if (WIDTH == 0 || CNT_W < $clog2(WIDTH + 1) || COVER_TOTAL < WIDTH) begin : g_bad_params
  end

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hit_q, hit_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [WIDTH-1:0]   new_hits;
  logic [SelW-1:0]    sel;
  logic               found;
  logic [CNT_W:0]     pop;
  logic [CNT_W:0]     cnt_sum;

  always_comb begin
    new_hits = valid_i & ~hit_q;

    // Lowest pending point, taken from pend_q so that bits set at this edge
    // only become eligible at the next one.
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend_q[i] && !found) begin
        found = 1'b1;
        sel   = SelW'(i);
      end
    end

    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + (CNT_W + 1)'(new_hits[i]);
    end
    // Both operands fit in CNT_W bits, so the carry bit flags saturation.
    cnt_sum = {1'b0, cnt_q} + pop;

    hit_d   = hit_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    idx_d   = idx_q;

    if (clear_i) begin
      hit_d   = '0;
      pend_d  = '0;
      cnt_d   = '0;
      state_d = StEmpty;
      idx_d   = '0;
    end else begin
      hit_d  = hit_q | new_hits;
      pend_d = pend_q | new_hits;
      cnt_d  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      // Output slot is free when empty or being drained this edge.
      if (state_q == StEmpty || out_ready_i) begin
        if (found) begin
          pend_d[sel] = 1'b0;
          idx_d       = IDX_W'(COVER_INDEX) + IDX_W'(sel);
          state_d     = StHold;
        end else begin
          state_d = StEmpty;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StEmpty;
      hit_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid_o     = (state_q == StHold);
  assign out_index_o     = idx_q;
  assign covered_map_o   = hit_q;
  assign covered_count_o = cnt_q;
  assign all_covered_o   = &hit_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector (WIDTH=2, COVER_INDEX=100).
// A reference model tracks covered points, a pending list and the accepted
// index stream; directed steps follow the test plan, then random traffic.
module tb_cover_toggle_collector;

  localparam int unsigned     W    = 2;
  localparam longint unsigned BASE = 100;
  localparam int              CMAX = 65535;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  valid = '0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [63:0]   out_index;
  logic [W-1:0]  covered_map;
  logic [15:0]   covered_count;
  logic          all_covered;

  cover_toggle_collector #(
    .WIDTH       (W),
    .COVER_INDEX (BASE),
    .COVER_TOTAL (8940),
    .IDX_W       (64),
    .CNT_W       (16)
  ) dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .valid_i         (valid),
    .clear_i         (clear),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_index_o     (out_index),
    .covered_map_o   (covered_map),
    .covered_count_o (covered_count),
    .all_covered_o   (all_covered)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit      m_hit[W];
  int      m_pend[$];
  int      m_cnt;
  bit      m_ov;
  longint  m_idx;
  longint  m_acc[$];
  longint  got[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_hit[i]) m_hit[i] = 0;
    m_pend.delete();
    m_cnt = 0;
    m_ov  = 0;
    m_idx = 0;
  endfunction

  // One clock edge in terms of the behaviour: free slot takes lowest
  // pending point; fresh hits join the pending list afterwards.
  function automatic void model_edge(logic [W-1:0] v, logic clr, logic rdy);
    if (clr) begin
      model_reset();
      return;
    end
    if (m_ov && rdy) m_acc.push_back(m_idx);
    if (!m_ov || rdy) begin
      if (m_pend.size() > 0) begin
        int k = 0;
        for (int i = 1; i < m_pend.size(); i++) if (m_pend[i] < m_pend[k]) k = i;
        m_idx = BASE + longint'(m_pend[k]);
        m_pend.delete(k);
        m_ov = 1;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (v[i] && !m_hit[i]) begin
        m_hit[i] = 1;
        m_pend.push_back(i);
        if (m_cnt < CMAX) m_cnt++;
      end
    end
  endfunction

  function automatic logic [W-1:0] model_map();
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = m_hit[i];
    return m;
  endfunction

  task automatic compare_all(string tag);
    logic [W-1:0] m;
    m = model_map();
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    if (m_ov) chk({tag, ".out_index"}, out_index, m_idx);
    chk({tag, ".covered_map"}, 64'(covered_map), 64'(m));
    chk({tag, ".covered_count"}, 64'(covered_count), 64'(m_cnt));
    chk({tag, ".all_covered"}, 64'(all_covered), 64'(&m));
  endtask

  task automatic step(string tag, logic [W-1:0] v, logic clr, logic rdy);
    valid     = v;
    clear     = clr;
    out_ready = rdy;
    if (out_valid && rdy && !clr) got.push_back(out_index);
    model_edge(v, clr, rdy);
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_index"}, out_index, 64'd0);
    chk({tag, ".covered_map"}, 64'(covered_map), 64'd0);
    chk({tag, ".covered_count"}, 64'(covered_count), 64'd0);
    chk({tag, ".all_covered"}, 64'(all_covered), 64'd0);
  endtask

  int n0;

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single hit on point 0: map/count after E0, report after E1, one transfer.
    n0 = got.size();
    step("t1.e0", 2'b01, 0, 0);
    chk("t1.map_e0", 64'(covered_map), 64'd1);
    chk("t1.cnt_e0", 64'(covered_count), 64'd1);
    chk("t1.ov_e0", 64'(out_valid), 64'd0);
    step("t1.e1", 2'b00, 0, 1);
    chk("t1.ov_e1", 64'(out_valid), 64'd1);
    chk("t1.idx_e1", out_index, 64'd100);
    step("t1.e2", 2'b00, 0, 1);
    step("t1.e3", 2'b00, 0, 1);
    chk("t1.transfers", 64'(got.size() - n0), 64'd1);
    step("t1.clr", 2'b00, 1, 0);

    // Both points at once: back-to-back 100, 101.
    step("t2.e0", 2'b11, 0, 1);
    chk("t2.cnt", 64'(covered_count), 64'd2);
    chk("t2.all", 64'(all_covered), 64'd1);
    step("t2.e1", 2'b00, 0, 1);
    chk("t2.idx0", out_index, 64'd100);
    step("t2.e2", 2'b00, 0, 1);
    chk("t2.ov1", 64'(out_valid), 64'd1);
    chk("t2.idx1", out_index, 64'd101);
    step("t2.e3", 2'b00, 0, 1);
    chk("t2.ov_end", 64'(out_valid), 64'd0);
    step("t2.clr", 2'b00, 1, 0);

    // Repeated hits on point 0 report once.
    n0 = got.size();
    for (int i = 0; i < 10; i++) step("t3.rep", 2'b01, 0, 1);
    step("t3.tail", 2'b00, 0, 1);
    chk("t3.cnt", 64'(covered_count), 64'd1);
    chk("t3.transfers", 64'(got.size() - n0), 64'd1);
    chk("t3.first", got[n0], 64'd100);
    step("t3.clr", 2'b00, 1, 0);

    // Stall: 100 held stable, point 1 hit during stall follows.
    step("t4.e0", 2'b01, 0, 0);
    step("t4.s0", 2'b10, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("t4.stall", 2'b00, 0, 0);
      chk("t4.hold_idx", out_index, 64'd100);
      chk("t4.hold_ov", 64'(out_valid), 64'd1);
    end
    step("t4.acc", 2'b00, 0, 1);
    chk("t4.next_idx", out_index, 64'd101);
    step("t4.acc2", 2'b00, 0, 1);
    step("t4.clr", 2'b00, 1, 0);

    // Clear while holding, with a same-cycle hit that must be dropped.
    step("t5.e0", 2'b01, 0, 0);
    step("t5.hold", 2'b00, 0, 0);
    step("t5.clr", 2'b10, 1, 1);
    check_zero("t5.after_clr");
    step("t5.idle", 2'b00, 0, 1);
    step("t5.idle2", 2'b00, 0, 1);
    chk("t5.no_pt1", 64'(out_valid), 64'd0);
    step("t5.hit1", 2'b10, 0, 1);
    step("t5.rep1", 2'b00, 0, 1);
    chk("t5.idx101", out_index, 64'd101);
    step("t5.drain", 2'b00, 0, 1);

    // Asynchronous reset mid-HOLD.
    step("t6.e0", 2'b01, 0, 0);
    step("t6.hold", 2'b00, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    check_zero("t6.async");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step("t6.e0b", 2'b01, 0, 1);
    step("t6.e1b", 2'b00, 0, 1);
    chk("t6.idx100", out_index, 64'd100);
    chk("t6.ov", 64'(out_valid), 64'd1);
    step("t6.drain", 2'b00, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", W'($urandom), ($urandom_range(0, 19) == 0), 1'($urandom));
    end

    // Accepted index stream must match the model's stream exactly.
    chk("stream.len", 64'(got.size()), 64'(m_acc.size()));
    for (int i = 0; i < got.size() && i < m_acc.size(); i++) begin
      chk("stream.idx", got[i], m_acc[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Hardware-side receiver for toggle-coverage strobes: takes the per-point `valid` hit vector of one coverage group and records first-time hits in a sticky bitmap. Reports each newly covered point exactly once as an absolute cover index over a valid/ready stream, and keeps a saturating covered-point count. Sits beside a toggle group in synthesis and FPGA builds, where no DPI call is available, and feeds the coverage drain or uploader.

## Interface
- `WIDTH`, default 2: number of cover points in the group; must be at least 1.
- `COVER_INDEX`, default 0: absolute index of point 0; point i reports `COVER_INDEX + i`.
- `COVER_TOTAL`, default 8940: global point count; informational, not used in logic.
- `IDX_W`, default 64: width of `out_index`.
- `CNT_W`, default 16: width of `covered_count`; must be at least clog2(WIDTH+1).

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `valid` in WIDTH: per-point hit strobe, sampled every rising edge.
- `clear` in 1: synchronous clear of coverage state.
- `out_valid` out 1: `out_index` holds an unreported newly covered point.
- `out_ready` in 1: the consumer accepts `out_index`.
- `out_index` out IDX_W: absolute cover index.
- `covered_map` out WIDTH: sticky hit bitmap.
- `covered_count` out CNT_W: popcount of hits, saturating.
- `all_covered` out 1: high when every bit of `covered_map` is 1.

## Operation
- **State**
  - `hit[WIDTH]`: sticky hit bitmap, drives `covered_map`.
  - `pend[WIDTH]`: hits not yet reported.
  - Output register: `out_index` plus a state bit, EMPTY or HOLD; `out_valid` = (state == HOLD).
- **Capture** (each edge, when `clear` = 0)
  - `new = valid & ~hit`.
  - `hit |= new`.
  - `pend |= new`.
  - `covered_count += popcount(new)`, saturating at 2^CNT_W-1.
  - A repeat `valid` on an already-hit point has no effect.
- **Reporting FSM**
  - EMPTY, with `pend` nonzero before the edge: load the lowest set index j, clear `pend[j]`, go to HOLD.
  - HOLD with `out_ready` = 0: hold; `out_index` stays stable.
  - HOLD with `out_ready` = 1 and `pend` nonzero before the edge: load the next lowest index in the same edge and stay in HOLD. This gives back-to-back transfers at 1 per cycle.
  - HOLD with `out_ready` = 1 and `pend` zero: go to EMPTY.
  - Pend bits set at an edge become eligible only from the following edge.
- **Clear**
  - Zeroes `hit`, `pend` and `covered_count`, and forces EMPTY. A held but unaccepted index is dropped.
  - `clear` wins over `valid` in the same cycle; that cycle's hits are discarded.
  - `out_ready` is ignored while `clear` = 1.
- **Invariant**: each point is reported at most once between clears, so no FIFO is needed and no overflow is possible.

## Timing
- Reset values: `out_valid` = 0, `out_index` = 0, `covered_map` = 0, `covered_count` = 0, `all_covered` = 0 (with WIDTH ≥ 1).
- Reset asserted mid-transfer: immediate, asynchronous return to the reset values; no report is emitted for the dropped index.
- Latency, measured from the edge E0 at which `valid[i]` is sampled:
  - `covered_map[i]` and `covered_count` update after E0.
  - `out_valid` with `COVER_INDEX + i` appears after E1, at the earliest.
- A transfer completes on any edge where `out_valid` and `out_ready` are both 1.
- `out_valid` never drops without a handshake, except on `clear` or `reset`.
- `out_index` is registered; there is no combinational path from any input to any output.
- Throughput: one index per cycle while `pend` is nonzero and `out_ready` is held high.

## Test plan
- Reset, then `valid` = 2'b01 for one cycle with `COVER_INDEX` = 100:
  - `covered_map` = 01 and `covered_count` = 1 after E0.
  - `out_valid` = 1 with `out_index` = 100 after E1.
  - With `out_ready` = 1, exactly one transfer occurs.
- `valid` = 2'b11 in one cycle, `out_ready` = 1:
  - `covered_count` = 2 and `all_covered` = 1.
  - Indices 100 then 101 are reported on consecutive cycles.
- `valid` = 01 repeated for 10 cycles:
  - Exactly one report (100); `covered_count` stays 1.
- `out_ready` = 0 for 5 cycles after a hit:
  - `out_index` = 100 stays stable with `out_valid` = 1.
  - A hit on point 1 during the stall is reported (101) right after 100 is accepted.
- `clear` asserted while holding 100, with `valid` = 10 in the same cycle:
  - After the edge, everything is zero and `out_valid` = 0.
  - Point 1 is not recorded.
  - A later `valid` = 10 reports 101.
- `reset` asserted asynchronously mid-HOLD:
  - Outputs go to zero before the next clock edge.
  - After deassertion, a new `valid` = 01 reports 100 again.
